// File: rtl/alui_seq_if.sv
// alui_seq_if: decoder-side handshake and datapath control strobes for the
// ALU-immediate sequencer. The decoder is the master; the sequencer is the slave.
interface alui_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 4
);
    logic              start;
    logic [15:0]       instruction;
    logic              busy;
    logic              done;
    logic              err;
    logic              pc_inc;
    logic [NREG-1:0]   rx_out;
    logic [NREG-1:0]   rx_in;
    logic              alu_in0;
    logic              alu_in1;
    logic              alu_latch;
    logic              alu_out_en;
    logic              imm_en;
    logic [DATA_W-1:0] imm_out;

    modport master (
        output start, instruction,
        input  busy, done, err, pc_inc, rx_out, rx_in,
               alu_in0, alu_in1, alu_latch, alu_out_en, imm_en, imm_out
    );

    modport slave (
        input  start, instruction,
        output busy, done, err, pc_inc, rx_out, rx_in,
               alu_in0, alu_in1, alu_latch, alu_out_en, imm_en, imm_out
    );
endinterface

// File: rtl/alui_seq.sv
// alui_seq: ALU-immediate instruction sequencer. Latches one instruction on
// accept, then steps PC -> RD -> IMM -> LDB -> EXE -> WBD -> WB -> DONE,
// decoding every control strobe from the state and the latched fields.
// An out-of-range register select short-cuts PC -> DONE with err.
module alui_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NREG     = 4,
    parameter int unsigned IMM_W    = 6,
    parameter int unsigned SEL_W    = 6,
    parameter logic [3:0]  OPC_A    = 4'h0,
    parameter logic [3:0]  OPC_B    = 4'h1,
    parameter bit          SIGN_EXT = 1'b1
) (
    input logic        clk,
    input logic        rst,
    alui_seq_if.slave  bus
);
    localparam int unsigned FLD_W = IMM_W + SEL_W;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PC   = 4'd1;
    localparam logic [3:0] S_RD   = 4'd2;
    localparam logic [3:0] S_IMM  = 4'd3;
    localparam logic [3:0] S_LDB  = 4'd4;
    localparam logic [3:0] S_EXE  = 4'd5;
    localparam logic [3:0] S_WBD  = 4'd6;
    localparam logic [3:0] S_WB   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    logic [3:0]              state;
    logic [3:0]              state_nx;
    logic [FLD_W-1:0]        instr_q;
    logic [DATA_W-1:0]       imm_q;

    logic [SEL_W-1:0]        sel;
    logic [IMM_W-1:0]        imm;
    logic signed [IMM_W-1:0] imm_s;
    logic [DATA_W-1:0]       imm_ext;
    logic [NREG-1:0]         sel_onehot;
    logic                    sel_bad;
    logic                    opc_ok;
    logic                    accept;

    logic                    pc_inc_c;
    logic [NREG-1:0]         rx_out_c;
    logic [NREG-1:0]         rx_in_c;
    logic                    alu_in0_c;
    logic                    alu_in1_c;
    logic                    alu_latch_c;
    logic                    alu_out_en_c;
    logic                    imm_en_c;
    logic                    done_c;
    logic                    err_c;

    assign sel     = instr_q[FLD_W-1:IMM_W];
    assign imm     = instr_q[IMM_W-1:0];
    assign imm_s   = $signed(imm);
    assign imm_ext = SIGN_EXT ? DATA_W'(imm_s) : DATA_W'(imm);
    assign sel_bad = 32'(sel) >= NREG;

    assign opc_ok  = (bus.instruction[15:12] == OPC_A) || (bus.instruction[15:12] == OPC_B);
    assign accept  = (state == S_IDLE) && bus.start && opc_ok;

    // Register 0 maps to the MSB of the one-hot enables.
    for (genvar g = 0; g < NREG; g++) begin : g_onehot
        assign sel_onehot[NREG-1-g] = (32'(sel) == g);
    end

    // Next-state: fixed walk through the datapath steps, early exit on bad select.
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = accept ? S_PC : S_IDLE;
            S_PC:    state_nx = sel_bad ? S_DONE : S_RD;
            S_RD:    state_nx = S_IMM;
            S_IMM:   state_nx = S_LDB;
            S_LDB:   state_nx = S_EXE;
            S_EXE:   state_nx = S_WBD;
            S_WBD:   state_nx = S_WB;
            S_WB:    state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and instruction latch (instruction captured only on accept).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                instr_q <= bus.instruction[FLD_W-1:0];
            end
        end
    end

    // Extended immediate: cleared on accept, loaded when entering IMM, then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imm_q <= '0;
        end else if (accept) begin
            imm_q <= '0;
        end else if (state == S_RD) begin
            imm_q <= imm_ext;
        end
    end

    // Control strobes decoded purely from state and latched fields.
    always_comb begin
        pc_inc_c     = 1'b0;
        rx_out_c     = '0;
        rx_in_c      = '0;
        alu_in0_c    = 1'b0;
        alu_in1_c    = 1'b0;
        alu_latch_c  = 1'b0;
        alu_out_en_c = 1'b0;
        imm_en_c     = 1'b0;
        done_c       = 1'b0;
        err_c        = 1'b0;
        case (state)
            S_PC:   pc_inc_c = 1'b1;
            S_RD: begin
                rx_out_c  = sel_onehot;
                alu_in0_c = 1'b1;
            end
            S_IMM:  imm_en_c = 1'b1;
            S_LDB: begin
                imm_en_c  = 1'b1;
                alu_in1_c = 1'b1;
            end
            S_EXE:  alu_latch_c = 1'b1;
            S_WBD:  alu_out_en_c = 1'b1;
            S_WB: begin
                alu_out_en_c = 1'b1;
                rx_in_c      = sel_onehot;
            end
            S_DONE: begin
                done_c = 1'b1;
                err_c  = sel_bad;
            end
            default: ;
        endcase
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_c;
    assign bus.err        = err_c;
    assign bus.pc_inc     = pc_inc_c;
    assign bus.rx_out     = rx_out_c;
    assign bus.rx_in      = rx_in_c;
    assign bus.alu_in0    = alu_in0_c;
    assign bus.alu_in1    = alu_in1_c;
    assign bus.alu_latch  = alu_latch_c;
    assign bus.alu_out_en = alu_out_en_c;
    assign bus.imm_en     = imm_en_c;
    assign bus.imm_out    = imm_q;
endmodule

// File: tb/tb_alui_seq.sv
// tb_alui_seq: three sequencer instances (16-bit/4-reg sign-extend,
// 16-bit/4-reg zero-extend, 32-bit/8-reg sign-extend). Stimulus pushes the
// hand-computed expected response; a monitor traces each operation and
// compares against the queue when done is seen.
module tb_alui_seq;
    typedef struct {
        int          lat;
        logic        err;
        logic [7:0]  rx;
        logic [31:0] imm;
    } exp_t;

    localparam int B_BUSY = 8, B_DONE = 7, B_ERR = 6, B_PC = 5, B_A0 = 4,
                   B_A1 = 3, B_AL = 2, B_AOE = 1, B_IMEN = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        start_v [3];
    logic [15:0] instr_v [3];
    logic [8:0]  sig_v   [3];
    logic [7:0]  rxo_v   [3];
    logic [7:0]  rxi_v   [3];
    logic [31:0] imm_v   [3];

    exp_t exp_q [3][$];

    alui_seq_if #(.DATA_W(16), .NREG(4)) if0 ();
    alui_seq_if #(.DATA_W(16), .NREG(4)) if1 ();
    alui_seq_if #(.DATA_W(32), .NREG(8)) if2 ();

    alui_seq #(.DATA_W(16), .NREG(4), .SIGN_EXT(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    alui_seq #(.DATA_W(16), .NREG(4), .SIGN_EXT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    alui_seq #(.DATA_W(32), .NREG(8), .SIGN_EXT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.instruction = instr_v[0];
    assign if1.instruction = instr_v[1];
    assign if2.instruction = instr_v[2];

    assign sig_v[0] = {if0.busy, if0.done, if0.err, if0.pc_inc, if0.alu_in0, if0.alu_in1,
                       if0.alu_latch, if0.alu_out_en, if0.imm_en};
    assign sig_v[1] = {if1.busy, if1.done, if1.err, if1.pc_inc, if1.alu_in0, if1.alu_in1,
                       if1.alu_latch, if1.alu_out_en, if1.imm_en};
    assign sig_v[2] = {if2.busy, if2.done, if2.err, if2.pc_inc, if2.alu_in0, if2.alu_in1,
                       if2.alu_latch, if2.alu_out_en, if2.imm_en};
    assign rxo_v[0] = 8'(if0.rx_out);
    assign rxo_v[1] = 8'(if1.rx_out);
    assign rxo_v[2] = if2.rx_out;
    assign rxi_v[0] = 8'(if0.rx_in);
    assign rxi_v[1] = 8'(if1.rx_in);
    assign rxi_v[2] = if2.rx_in;
    assign imm_v[0] = 32'(if0.imm_out);
    assign imm_v[1] = 32'(if1.imm_out);
    assign imm_v[2] = if2.imm_out;

    function automatic exp_t mk(input int lat, input logic err, input logic [7:0] rx,
                                input logic [31:0] imm);
        exp_t e;
        e.lat = lat;
        e.err = err;
        e.rx  = rx;
        e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s[u%0d] got=%h want=%h", name, k, act, req);
        end
    endtask

    // Present one instruction with start for a single cycle; instruction is
    // scrambled right after the accepting edge.
    task automatic issue(input int k, input logic [15:0] ins, input bit take, input exp_t e);
        @(posedge clk); #1;
        if (take) exp_q[k].push_back(e);
        start_v[k] = 1'b1;
        instr_v[k] = ins;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        instr_v[k] = ~ins;
        chk("accept_busy", k, 32'(sig_v[k][B_BUSY]), 32'(take));
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 60; i++) begin
            if (exp_q[k].size() == 0 && !sig_v[k][B_BUSY]) return;
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout[u%0d] got=pending%0d want=0", k, exp_q[k].size());
    endtask

    // Per-operation trace state for the monitor.
    bit          act_m  [3];
    int          cyc    [3];
    int          pc_cyc [3];
    int          rd_cyc [3];
    int          wb_cyc [3];
    logic [7:0]  rd_rx  [3];
    logic [7:0]  wb_rx  [3];
    logic [31:0] imm_sn [3];
    bit          strobe [3];
    bit          inv    [3];
    exp_t        em;

    // Monitor: trace strobes per operation, compare against the queue on done.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst || !sig_v[k][B_BUSY]) begin
                act_m[k] = 1'b0;
            end else begin
                if (!act_m[k]) begin
                    act_m[k] = 1'b1;
                    cyc[k] = 0; pc_cyc[k] = 0; rd_cyc[k] = 0; wb_cyc[k] = 0;
                    rd_rx[k] = '0; wb_rx[k] = '0; imm_sn[k] = '0;
                    strobe[k] = 1'b0; inv[k] = 1'b0;
                end
                cyc[k]++;
                if (sig_v[k][B_PC] && pc_cyc[k] == 0) pc_cyc[k] = cyc[k];
                if (sig_v[k][B_A0]) begin rd_cyc[k] = cyc[k]; rd_rx[k] = rxo_v[k]; end
                if (sig_v[k][B_A1]) imm_sn[k] = imm_v[k];
                if (rxi_v[k] != 0) begin wb_cyc[k] = cyc[k]; wb_rx[k] = rxi_v[k]; end
                if (sig_v[k][B_A0] || sig_v[k][B_A1] || sig_v[k][B_AL] || sig_v[k][B_AOE] ||
                    sig_v[k][B_IMEN] || rxo_v[k] != 0 || rxi_v[k] != 0)
                    strobe[k] = 1'b1;
                if ((rxo_v[k] != 0 && rxi_v[k] != 0) || (sig_v[k][B_IMEN] && sig_v[k][B_AOE]) ||
                    (sig_v[k][B_ERR] && !sig_v[k][B_DONE]))
                    inv[k] = 1'b1;
                if (sig_v[k][B_DONE]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done[u%0d] got=done want=none", k);
                    end else begin
                        em = exp_q[k].pop_front();
                        chk("latency", k, 32'(cyc[k]), 32'(em.lat));
                        chk("err", k, 32'(sig_v[k][B_ERR]), 32'(em.err));
                        chk("pc_cycle", k, 32'(pc_cyc[k]), 32'd1);
                        chk("invariants", k, 32'(inv[k]), 32'd0);
                        if (em.err) begin
                            chk("no_strobes", k, 32'(strobe[k]), 32'd0);
                        end else begin
                            chk("rd_cycle", k, 32'(rd_cyc[k]), 32'd2);
                            chk("rd_rx_out", k, 32'(rd_rx[k]), 32'(em.rx));
                            chk("imm_out", k, imm_sn[k], em.imm);
                            chk("wb_cycle", k, 32'(wb_cyc[k]), 32'd7);
                            chk("wb_rx_in", k, 32'(wb_rx[k]), 32'(em.rx));
                        end
                    end
                end
            end
        end
    end

    exp_t none;

    initial begin
        none = mk(0, 1'b0, 8'h00, 32'h0);
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            instr_v[k] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_strobes", k, 32'(sig_v[k]), 32'd0);
            chk("rst_rx", k, 32'({rxo_v[k], rxi_v[k]}), 32'd0);
            chk("rst_imm", k, imm_v[k], 32'd0);
        end
        rst = 1'b1;

        // Normal op: opc 0, sel 2, imm 5
        issue(0, 16'h0085, 1'b1, mk(8, 1'b0, 8'h02, 32'h0000_0005));
        drain(0);
        // Immediate 6'b111101, sel 1: sign- and zero-extended
        issue(0, 16'h007D, 1'b1, mk(8, 1'b0, 8'h04, 32'h0000_FFFD));
        drain(0);
        issue(1, 16'h007D, 1'b1, mk(8, 1'b0, 8'h04, 32'h0000_003D));
        drain(1);
        // Illegal select 5 with NREG 4
        issue(0, 16'h1145, 1'b1, mk(2, 1'b1, 8'h00, 32'h0));
        drain(0);

        // Opcode 3 is rejected
        issue(0, 16'h3085, 1'b0, none);
        repeat (3) @(posedge clk);
        #1;
        chk("reject_idle", 0, 32'(sig_v[0][B_BUSY]), 32'd0);

        // New start during RD is ignored; original op finishes unchanged
        issue(0, 16'h0085, 1'b1, mk(8, 1'b0, 8'h02, 32'h0000_0005));
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        instr_v[0] = 16'h0045;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        drain(0);

        // Reset during WB aborts without done
        issue(0, 16'h0085, 1'b1, mk(8, 1'b0, 8'h02, 32'h0000_0005));
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_rx_in", 0, 32'(rxi_v[0]), 32'h2);
        rst = 1'b0;
        #1;
        chk("midrst_strobes", 0, 32'(sig_v[0]), 32'd0);
        chk("midrst_rx", 0, 32'({rxo_v[0], rxi_v[0]}), 32'd0);
        chk("midrst_imm", 0, imm_v[0], 32'd0);
        exp_q[0].delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        issue(0, 16'h1085, 1'b1, mk(8, 1'b0, 8'h02, 32'h0000_0005));
        drain(0);

        // 32-bit / 8-register instance, back-to-back ops 9 cycles apart
        issue(2, 16'h01E0, 1'b1, mk(8, 1'b0, 8'h01, 32'hFFFF_FFE0));
        repeat (7) @(posedge clk);
        issue(2, 16'h001F, 1'b1, mk(8, 1'b0, 8'h80, 32'h0000_001F));
        repeat (7) @(posedge clk);
        issue(2, 16'h10C0, 1'b1, mk(8, 1'b0, 8'h10, 32'h0000_0000));
        repeat (7) @(posedge clk);
        issue(2, 16'h0205, 1'b1, mk(2, 1'b1, 8'h00, 32'h0));
        drain(2);

        for (int k = 0; k < 3; k++) drain(k);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
